// File: rtl/key_debounce.sv
// Synchronises, debounces and edge-detects active-low push-button keys.
// Each channel yields a clean pressed level plus one-cycle press/release pulses.
module key_debounce #(
   parameter int NUM_KEYS        = 4,
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic [NUM_KEYS-1:0] i_key_n,
   output logic [NUM_KEYS-1:0] o_level,
   output logic [NUM_KEYS-1:0] o_press,
   output logic [NUM_KEYS-1:0] o_release
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] LAST_CNT = CW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic {
      ST_STABLE,
      ST_CHECK
   } state_t;

   logic [NUM_KEYS-1:0] sync1;
   logic [NUM_KEYS-1:0] sync2;

   // Both stages reset to the released level so reset release never fakes a press edge.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sync1 <= '1;
         sync2 <= '1;
      end else begin
         // NOTE: non-blocking so stage2 takes the previous stage1 value, forming a real 2-flop chain.
         sync1 <= i_key_n;
         sync2 <= sync1;
      end
   end

   for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
      state_t        state;
      logic [CW-1:0] cnt;
      logic          p_sync;
      logic          level_q;
      logic          press_q;
      logic          rel_q;

      assign p_sync = ~sync2[k];

      always_ff @(posedge i_clk or negedge i_rst_n) begin
         if (!i_rst_n) begin
            state   <= ST_STABLE;
            cnt     <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
         end else begin
            press_q <= 1'b0;
            rel_q   <= 1'b0;
            case (state)
               ST_STABLE: begin
                  if (p_sync != level_q) begin
                     state <= ST_CHECK;
                     cnt   <= CW'(1);
                  end else begin
                     cnt   <= '0;
                  end
               end
               ST_CHECK: begin
                  if (p_sync == level_q) begin
                     state <= ST_STABLE;
                     cnt   <= '0;
                  end else if (cnt == LAST_CNT) begin
                     // Accepted change: the pulse lines up with the first cycle of the new level.
                     level_q <= p_sync;
                     press_q <= p_sync;
                     rel_q   <= ~p_sync;
                     state   <= ST_STABLE;
                     cnt     <= '0;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               default: begin
                  state <= ST_STABLE;
                  cnt   <= '0;
               end
            endcase
         end
      end

      assign o_level[k]   = level_q;
      assign o_press[k]   = press_q;
      assign o_release[k] = rel_q;
   end

endmodule

// File: tb/tb_key_debounce.sv
// Directed self-checking bench for key_debounce with two keys and a 4-cycle filter.
// Outputs are compared after every edge against hand-derived expected vectors.
module tb_key_debounce;

   localparam int NK = 2;
   localparam int DC = 4;

   logic          i_clk = 1'b0;
   logic          i_rst_n = 1'b0;
   logic [NK-1:0] i_key_n = '1;
   logic [NK-1:0] o_level;
   logic [NK-1:0] o_press;
   logic [NK-1:0] o_release;

   int errors = 0;
   int checks = 0;

   key_debounce #(
      .NUM_KEYS       (NK),
      .DEBOUNCE_CYCLES(DC)
   ) dut (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_key_n  (i_key_n),
      .o_level  (o_level),
      .o_press  (o_press),
      .o_release(o_release)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance one rising edge, then compare {level, press, release} 1 time unit later.
   task automatic step(input string tag, input logic [NK-1:0] lvl,
                       input logic [NK-1:0] prs, input logic [NK-1:0] rel);
      @(posedge i_clk);
      #1;
      check(tag, {26'd0, o_level, o_press, o_release}, {26'd0, lvl, prs, rel});
   endtask

   initial begin
      // Reset with keys released
      i_key_n = 2'b11;
      i_rst_n = 1'b0;
      for (int i = 0; i < 3; i++) step($sformatf("in_reset[%0d]", i), 2'b00, 2'b00, 2'b00);
      i_rst_n = 1'b1;
      for (int i = 0; i < 10; i++) step($sformatf("post_reset[%0d]", i), 2'b00, 2'b00, 2'b00);

      // Clean press of key 0, then release
      i_key_n = 2'b10;
      for (int i = 0; i < 10; i++)
         step($sformatf("clean_press[%0d]", i), (i >= 5) ? 2'b01 : 2'b00,
              (i == 5) ? 2'b01 : 2'b00, 2'b00);
      i_key_n = 2'b11;
      for (int i = 0; i < 8; i++)
         step($sformatf("clean_rel[%0d]", i), (i >= 5) ? 2'b00 : 2'b01,
              2'b00, (i == 5) ? 2'b01 : 2'b00);

      // Bounce: low 3, high 1, low held; last 1->0 lands at edge 4
      for (int i = 0; i < 16; i++) begin
         i_key_n = (i == 3) ? 2'b11 : 2'b10;
         step($sformatf("bounce_press[%0d]", i), (i >= 9) ? 2'b01 : 2'b00,
              (i == 9) ? 2'b01 : 2'b00, 2'b00);
      end
      i_key_n = 2'b11;
      for (int i = 0; i < 10; i++)
         step($sformatf("bounce_rel[%0d]", i), (i >= 5) ? 2'b00 : 2'b01,
              2'b00, (i == 5) ? 2'b01 : 2'b00);

      // Glitch on key 1 shorter than the filter
      for (int i = 0; i < 23; i++) begin
         i_key_n = (i < 3) ? 2'b01 : 2'b11;
         step($sformatf("glitch[%0d]", i), 2'b00, 2'b00, 2'b00);
      end

      // Both keys together
      i_key_n = 2'b00;
      for (int i = 0; i < 10; i++)
         step($sformatf("both_press[%0d]", i), (i >= 5) ? 2'b11 : 2'b00,
              (i == 5) ? 2'b11 : 2'b00, 2'b00);
      i_key_n = 2'b11;
      for (int i = 0; i < 10; i++)
         step($sformatf("both_rel[%0d]", i), (i >= 5) ? 2'b00 : 2'b11,
              2'b00, (i == 5) ? 2'b11 : 2'b00);

      // Reset two cycles into a key-0 count, key held through reset release
      i_key_n = 2'b10;
      for (int i = 0; i < 4; i++) step($sformatf("pre_rst_cnt[%0d]", i), 2'b00, 2'b00, 2'b00);
      i_rst_n = 1'b0;
      #1;
      check("rst_async_clear", {26'd0, o_level, o_press, o_release}, 32'd0);
      for (int i = 0; i < 3; i++) step($sformatf("held_in_rst[%0d]", i), 2'b00, 2'b00, 2'b00);
      i_rst_n = 1'b1;
      for (int i = 1; i <= 12; i++)
         step($sformatf("held_after_rst[%0d]", i), (i >= 6) ? 2'b01 : 2'b00,
              (i == 6) ? 2'b01 : 2'b00, 2'b00);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/key_debounce.md
# key_debounce

Debounces and edge-detects the DE2-115 push-button keys before they reach the random-number generator stage. Each raw, active-low, asynchronous key input is synchronised, filtered for bounce, and turned into a clean level plus single-cycle press and release pulses. `o_press[0]` drives the generator's `i_start` input; the remaining keys are available to other consumers.

## Interface
- `NUM_KEYS`, default 4: number of independent key channels (legal range 1..8).
- `DEBOUNCE_CYCLES`, default 500000: consecutive stable cycles required to accept a change (10 ms at 50 MHz). Minimum 2.
- `i_clk` input, 1 bit: single system clock. All logic is on the rising edge.
- `i_rst_n` input, 1 bit: asynchronous, active-low reset.
- `i_key_n` input, `NUM_KEYS` bits: raw key pins, 0 = pressed. Asynchronous to `i_clk`.
- `o_level` output, `NUM_KEYS` bits: debounced key state, 1 = pressed.
- `o_press` output, `NUM_KEYS` bits: one-cycle pulse when `o_level[k]` goes 0→1.
- `o_release` output, `NUM_KEYS` bits: one-cycle pulse when `o_level[k]` goes 1→0.

## Operation
- Each channel is independent and identical. There is no cross-key interaction, and simultaneous events on different keys are handled in parallel.
- **Synchroniser:** two-flop chain per key, both flops reset to 1 (released). The synchronised pressed bit is `p_sync[k] = ~stage2[k]`.
- **Counter:** width is `$clog2(DEBOUNCE_CYCLES+1)`. It never exceeds `DEBOUNCE_CYCLES`.
- **State machine per key: STABLE and CHECK.**
  - STABLE, `p_sync == o_level`: stay; counter = 0.
  - STABLE, `p_sync != o_level`: go to CHECK; counter = 1.
  - CHECK, `p_sync == o_level` (bounce back): go to STABLE; counter = 0; no output change.
  - CHECK, `p_sync != o_level`, counter < `DEBOUNCE_CYCLES`-1: counter += 1.
  - CHECK, `p_sync != o_level`, counter == `DEBOUNCE_CYCLES`-1: `o_level` toggles; the matching pulse (`o_press` or `o_release`) is asserted; go to STABLE; counter = 0.
- **Pulses:**
  - Registered, asserted in exactly the first cycle of the new `o_level` value, deasserted the next cycle.
  - Press and release on the same key can never coincide.
  - Two consecutive accepted changes on one key are at least `DEBOUNCE_CYCLES` cycles apart.
- **Reset values:** sync flops 1; `o_level` 0; `o_press` 0; `o_release` 0; counters 0; state STABLE.
  - Reset asserted mid-CHECK discards the count with no pulse.
  - A key held down through reset deassertion is treated as a new press: `o_press` fires once after the normal latency.

## Timing
- Let the pin change be set up before rising edge E.
  - stage1 captures at E; stage2 at E+1.
  - The differing value is sampled at edges E+2 … E+1+`DEBOUNCE_CYCLES`.
  - `o_level` and the pulse change after edge E+1+`DEBOUNCE_CYCLES`.
- Total latency is `DEBOUNCE_CYCLES`+2 edges.
- A bounce that reverts before the final edge restarts the full count from the next change.
- Any pin excursion shorter than `DEBOUNCE_CYCLES` cycles (after sync) produces no output activity.
- Outputs are purely registered: no combinational path from `i_key_n` to any output.

## Test plan
All scenarios use `NUM_KEYS`=2 and `DEBOUNCE_CYCLES`=4.
- **Reset:** drive `i_rst_n`=0 with keys released, release reset, hold 10 cycles → `o_level`=00, `o_press`=00, `o_release`=00 throughout.
- **Clean press:** `i_key_n[0]` goes 1→0 before edge 0 and is held → `o_level[0]`=1 after edge 5; `o_press[0]`=1 for only the cycle after edge 5; key 1 outputs stay 0.
- **Bounce, then release:**
  - Press pattern low 3 cycles, high 1 cycle, low held → exactly one `o_press[0]` pulse, 6 edges after the last 1→0 transition.
  - Then `i_key_n[0]` 0→1 held → `o_release[0]` single pulse 6 edges later; `o_level[0]`=0.
- **Glitch rejection:** `i_key_n[1]` low for 3 cycles, then high → `o_level[1]`, `o_press[1]`, `o_release[1]` stay 0 for the following 20 cycles.
- **Simultaneous keys:** both keys 1→0 before the same edge → both `o_press` bits pulse in the same cycle, 6 edges later.
- **Reset interaction:**
  - Assert `i_rst_n`=0 two cycles into a key-0 press count → no pulse.
  - With key 0 still held, deassert reset → `o_press[0]` pulses exactly once, 6 edges after reset deassertion.
